// File: rtl/ex_mem_block.sv
// Execute stage: forwarding muxes, 32-bit ALU, destination select and the EX/MEM
// pipeline register that feeds the memory stage.
module ex_mem_block #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [DW-1:0] EX_RsData,
    input  logic [DW-1:0] EX_RtData,
    input  logic [DW-1:0] EX_Immediate,
    input  logic [RW-1:0] EX_RsReg,
    input  logic [RW-1:0] EX_RtReg,
    input  logic [RW-1:0] EX_RdReg,
    input  logic          EX_RegWrite,
    input  logic          EX_MemtoReg,
    input  logic          EX_MemRead,
    input  logic          EX_MemWrite,
    input  logic          EX_ALUSrc,
    input  logic          EX_RegDst,
    input  logic          EX_NoDest,
    input  logic [2:0]    EX_ALUCtrl,
    input  logic [DW-1:0] EX_Instruction,
    input  logic [DW-1:0] WB_WriteData,
    input  logic [RW-1:0] WB_DestReg,
    input  logic          WB_RegWrite,
    output logic [RW-1:0] EX_DestReg,
    output logic [DW-1:0] MEM_ALUOut,
    output logic [DW-1:0] MEM_WriteData,
    output logic [RW-1:0] MEM_DestReg,
    output logic          MEM_RegWrite,
    output logic          MEM_MemtoReg,
    output logic          MEM_MemRead,
    output logic          MEM_MemWrite,
    output logic          MEM_Overflow,
    output logic [DW-1:0] MEM_Instruction
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [RW-1:0] REG_ZERO = '0;

    function automatic logic [DW-1:0] alu_f(
        input logic [2:0]    op,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sb;
        logic [DW-1:0]        r;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = b << a[4:0];
            OP_SUB:  r = a - b;
            default: r = {{(DW-1){1'b0}}, (sa < sb)};
        endcase
        return r;
    endfunction

    // Signed overflow: ADD flips sign when both operands share a sign; SUB when they differ.
    function automatic logic ovf_f(
        input logic [2:0]    op,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] r
    );
        logic v;
        case (op)
            OP_ADD:  v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            OP_SUB:  v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    logic [DW-1:0] alu_out_q,  alu_out_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic [RW-1:0] dest_q,     dest_d;
    logic          regwrite_q, regwrite_d;
    logic          memtoreg_q, memtoreg_d;
    logic          memread_q,  memread_d;
    logic          memwrite_q, memwrite_d;
    logic          ovf_q,      ovf_d;
    logic [DW-1:0] instr_q,    instr_d;

    logic [DW-1:0] op_a;
    logic [DW-1:0] fwd_rt;
    logic [DW-1:0] op_b;
    logic          mem_fwd_ok;
    logic          wb_fwd_ok;

    // MEM stage outranks WB; register 0 is never a forwarding source.
    assign mem_fwd_ok = regwrite_q && (dest_q != REG_ZERO);
    assign wb_fwd_ok  = WB_RegWrite && (WB_DestReg != REG_ZERO);

    always_comb begin
        op_a = EX_RsData;
        if (mem_fwd_ok && (dest_q == EX_RsReg)) begin
            op_a = alu_out_q;
        end else if (wb_fwd_ok && (WB_DestReg == EX_RsReg)) begin
            op_a = WB_WriteData;
        end
    end

    always_comb begin
        fwd_rt = EX_RtData;
        if (mem_fwd_ok && (dest_q == EX_RtReg)) begin
            fwd_rt = alu_out_q;
        end else if (wb_fwd_ok && (WB_DestReg == EX_RtReg)) begin
            fwd_rt = WB_WriteData;
        end
    end

    assign op_b       = EX_ALUSrc ? EX_Immediate : fwd_rt;
    assign EX_DestReg = EX_NoDest ? REG_ZERO : (EX_RegDst ? EX_RdReg : EX_RtReg);

    always_comb begin
        alu_out_d  = alu_f(EX_ALUCtrl, op_a, op_b);
        ovf_d      = ovf_f(EX_ALUCtrl, op_a, op_b, alu_out_d);
        wdata_d    = fwd_rt;
        dest_d     = EX_DestReg;
        regwrite_d = EX_RegWrite;
        memtoreg_d = EX_MemtoReg;
        memread_d  = EX_MemRead;
        memwrite_d = EX_MemWrite;
        instr_d    = EX_Instruction;
    end

    // EX/MEM boundary: clearing everything on reset yields a bubble with no write side effects.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            alu_out_q  <= '0;
            wdata_q    <= '0;
            dest_q     <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            ovf_q      <= 1'b0;
            instr_q    <= '0;
        end else begin
            alu_out_q  <= alu_out_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            ovf_q      <= ovf_d;
            instr_q    <= instr_d;
        end
    end

    assign MEM_ALUOut      = alu_out_q;
    assign MEM_WriteData   = wdata_q;
    assign MEM_DestReg     = dest_q;
    assign MEM_RegWrite    = regwrite_q;
    assign MEM_MemtoReg    = memtoreg_q;
    assign MEM_MemRead     = memread_q;
    assign MEM_MemWrite    = memwrite_q;
    assign MEM_Overflow    = ovf_q;
    assign MEM_Instruction = instr_q;

endmodule

// File: tb/tb_ex_mem_block.sv
// Directed table-driven bench for ex_mem_block: forwarding, ALU ops, overflow,
// destination select and reset behaviour of the EX/MEM register.
module tb_ex_mem_block;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          Clock;
    logic          Reset;
    logic [DW-1:0] EX_RsData, EX_RtData, EX_Immediate, EX_Instruction;
    logic [RW-1:0] EX_RsReg, EX_RtReg, EX_RdReg;
    logic          EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite;
    logic          EX_ALUSrc, EX_RegDst, EX_NoDest;
    logic [2:0]    EX_ALUCtrl;
    logic [DW-1:0] WB_WriteData;
    logic [RW-1:0] WB_DestReg;
    logic          WB_RegWrite;
    logic [RW-1:0] EX_DestReg;
    logic [DW-1:0] MEM_ALUOut, MEM_WriteData, MEM_Instruction;
    logic [RW-1:0] MEM_DestReg;
    logic          MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite, MEM_Overflow;

    ex_mem_block #(.DW(DW), .RW(RW)) dut (
        .Clock(Clock), .Reset(Reset),
        .EX_RsData(EX_RsData), .EX_RtData(EX_RtData), .EX_Immediate(EX_Immediate),
        .EX_RsReg(EX_RsReg), .EX_RtReg(EX_RtReg), .EX_RdReg(EX_RdReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
        .EX_NoDest(EX_NoDest), .EX_ALUCtrl(EX_ALUCtrl), .EX_Instruction(EX_Instruction),
        .WB_WriteData(WB_WriteData), .WB_DestReg(WB_DestReg), .WB_RegWrite(WB_RegWrite),
        .EX_DestReg(EX_DestReg), .MEM_ALUOut(MEM_ALUOut), .MEM_WriteData(MEM_WriteData),
        .MEM_DestReg(MEM_DestReg), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_Overflow(MEM_Overflow),
        .MEM_Instruction(MEM_Instruction)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  ctrl;    // {RegWrite, MemtoReg, MemRead, MemWrite}
        logic        alusrc;
        logic        regdst;
        logic        nodest;
        logic [2:0]  alu;
        logic [31:0] instr;
        logic [31:0] wb_d;
        logic [4:0]  wb_r;
        logic        wb_we;
        logic [31:0] e_alu;
        logic [31:0] e_wd;
        logic [4:0]  e_dest;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        EX_RsData      = v.rs_d;
        EX_RtData      = v.rt_d;
        EX_Immediate   = v.imm;
        EX_RsReg       = v.rs;
        EX_RtReg       = v.rt;
        EX_RdReg       = v.rd;
        {EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite} = v.ctrl;
        EX_ALUSrc      = v.alusrc;
        EX_RegDst      = v.regdst;
        EX_NoDest      = v.nodest;
        EX_ALUCtrl     = v.alu;
        EX_Instruction = v.instr;
        WB_WriteData   = v.wb_d;
        WB_DestReg     = v.wb_r;
        WB_RegWrite    = v.wb_we;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".alu"},   MEM_ALUOut, 32'h0);
        chk({tag, ".wd"},    MEM_WriteData, 32'h0);
        chk({tag, ".dest"},  {27'h0, MEM_DestReg}, 32'h0);
        chk({tag, ".ctrl"},  {28'h0, MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite}, 32'h0);
        chk({tag, ".ovf"},   {31'h0, MEM_Overflow}, 32'h0);
        chk({tag, ".instr"}, MEM_Instruction, 32'h0);
    endtask

    initial begin
        //           rs_d          rt_d          imm     rs     rt     rd     ctrl     src  dst  nod  alu     instr         wb_d          wb_r   we    e_alu         e_wd          e_dest ovf
        vecs[0]  = '{32'd7,        32'd5,        32'd0, 5'd1,  5'd2,  5'd3,  4'b1000, 1'b0,1'b1,1'b0,3'b010,32'h00221820,32'h0,        5'd0,  1'b0, 32'd12,       32'd5,        5'd3,  1'b0};
        vecs[1]  = '{32'd0,        32'd7,        32'd0, 5'd3,  5'd1,  5'd4,  4'b1000, 1'b0,1'b1,1'b0,3'b110,32'h00612022,32'h0,        5'd0,  1'b0, 32'd5,        32'd7,        5'd4,  1'b0};
        vecs[2]  = '{32'h10,       32'd0,        32'd0, 5'd0,  5'd5,  5'd0,  4'b1000, 1'b1,1'b0,1'b0,3'b010,32'h20050010,32'h0,        5'd0,  1'b0, 32'h10,       32'h0,        5'd5,  1'b0};
        vecs[3]  = '{32'd0,        32'd0,        32'd0, 5'd5,  5'd0,  5'd6,  4'b1000, 1'b0,1'b1,1'b0,3'b001,32'h00A03025,32'h20,       5'd5,  1'b1, 32'h10,       32'h0,        5'd6,  1'b0};
        vecs[4]  = '{32'hF0F0,     32'h0FF0,     32'd0, 5'd0,  5'd0,  5'd9,  4'b1000, 1'b0,1'b1,1'b1,3'b000,32'h00004824,32'h20,       5'd5,  1'b1, 32'h00F0,     32'h0FF0,     5'd0,  1'b0};
        vecs[5]  = '{32'd0,        32'd0,        32'd0, 5'd5,  5'd0,  5'd7,  4'b1000, 1'b0,1'b1,1'b0,3'b001,32'h00A03825,32'h20,       5'd5,  1'b1, 32'h20,       32'h0,        5'd7,  1'b0};
        vecs[6]  = '{32'd0,        32'd0,        32'd0, 5'd0,  5'd0,  5'd8,  4'b1000, 1'b0,1'b1,1'b0,3'b010,32'h00004020,32'hFFFF,     5'd0,  1'b1, 32'h0,        32'h0,        5'd8,  1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'd1,        32'd0, 5'd9,  5'd10, 5'd11, 4'b1000, 1'b0,1'b1,1'b0,3'b111,32'h012A582A,32'h0,        5'd0,  1'b0, 32'd1,        32'd1,        5'd11, 1'b0};
        vecs[8]  = '{32'h7FFFFFFF, 32'd1,        32'd0, 5'd12, 5'd13, 5'd14, 4'b1000, 1'b0,1'b1,1'b0,3'b010,32'h018D7020,32'h0,        5'd0,  1'b0, 32'h80000000, 32'd1,        5'd14, 1'b1};
        vecs[9]  = '{32'h80000000, 32'd1,        32'd0, 5'd17, 5'd18, 5'd19, 4'b1000, 1'b0,1'b1,1'b0,3'b110,32'h02329822,32'h0,        5'd0,  1'b0, 32'h7FFFFFFF, 32'd1,        5'd19, 1'b1};
        vecs[10] = '{32'd4,        32'd3,        32'd0, 5'd20, 5'd21, 5'd22, 4'b1000, 1'b0,1'b1,1'b0,3'b101,32'h0295B004,32'h0,        5'd0,  1'b0, 32'h30,       32'd3,        5'd22, 1'b0};
        vecs[11] = '{32'd0,        32'h0F,       32'd0, 5'd22, 5'd23, 5'd24, 4'b1000, 1'b0,1'b1,1'b0,3'b011,32'h02D7C027,32'h0,        5'd0,  1'b0, 32'hFFFFFFC0, 32'h0F,       5'd24, 1'b0};
        vecs[12] = '{32'hFF00,     32'h0FF0,     32'd0, 5'd1,  5'd2,  5'd25, 4'b0000, 1'b0,1'b1,1'b0,3'b100,32'h0022C826,32'h0,        5'd0,  1'b0, 32'hF0F0,     32'h0FF0,     5'd25, 1'b0};
        vecs[13] = '{32'd5,        32'h0F,       32'd0, 5'd25, 5'd26, 5'd27, 4'b1000, 1'b0,1'b1,1'b0,3'b000,32'h033AD824,32'h0,        5'd0,  1'b0, 32'd5,        32'h0F,       5'd27, 1'b0};
        vecs[14] = '{32'd3,        32'd0,        32'd0, 5'd28, 5'd27, 5'd29, 4'b1000, 1'b0,1'b1,1'b0,3'b010,32'h039BE820,32'h0,        5'd0,  1'b0, 32'd8,        32'd5,        5'd29, 1'b0};
        vecs[15] = '{32'h100,      32'd0,        32'd8, 5'd15, 5'd16, 5'd0,  4'b0001, 1'b1,1'b0,1'b1,3'b010,32'hADF00008,32'hABCD,     5'd16, 1'b1, 32'h108,      32'hABCD,     5'd0,  1'b0};

        // Reset held low for two edges with a live instruction on the inputs.
        Reset = 1'b0;
        drive(vecs[0]);
        for (int c = 0; c < 2; c++) begin
            @(posedge Clock); #1;
            chk_zero($sformatf("rst%0d", c));
        end

        Reset = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.exdest", i), {27'h0, EX_DestReg}, {27'h0, vecs[i].e_dest});
            @(posedge Clock); #1;
            chk($sformatf("v%0d.alu", i),   MEM_ALUOut, vecs[i].e_alu);
            chk($sformatf("v%0d.wd", i),    MEM_WriteData, vecs[i].e_wd);
            chk($sformatf("v%0d.dest", i),  {27'h0, MEM_DestReg}, {27'h0, vecs[i].e_dest});
            chk($sformatf("v%0d.ctrl", i),
                {28'h0, MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite}, {28'h0, vecs[i].ctrl});
            chk($sformatf("v%0d.ovf", i),   {31'h0, MEM_Overflow}, {31'h0, vecs[i].e_ovf});
            chk($sformatf("v%0d.instr", i), MEM_Instruction, vecs[i].instr);
        end

        // Reset asserted right after the store: the store in flight must be squashed.
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk_zero("rst_mid");

        // Release: the held store reappears one edge later.
        Reset = 1'b1;
        @(posedge Clock); #1;
        chk("rel.memwrite", {31'h0, MEM_MemWrite}, 32'd1);
        chk("rel.alu", MEM_ALUOut, 32'h108);
        chk("rel.wd",  MEM_WriteData, 32'hABCD);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
